acc_load_sequencer: RTL and testbench

Sequences every accumulator load in the processor pipeline. It accepts load requests from the decode stage, drives the accumulator multiplexer select and the accumulator write enable, and runs a read-request/acknowledge handshake with the UART receive-data and SPI buffer peripherals, whose data is not valid immediately. While a handshake is outstanding it stalls the pipeline, and it aborts the read with an error pulse if the peripheral never acknowledges.

---
 rtl/acc_load_sequencer.sv | 135 +++++++++++++
 tb/tb_acc_load_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_load_sequencer.sv
// Accumulator load sequencer: drives the accumulator mux select and write enable, and
// runs the read request/acknowledge handshake with the UART receive and SPI buffer peripherals.
module acc_load_sequencer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reqValid,
  input  logic [2:0] reqSrc,
  output logic       reqReady,
  output logic [2:0] accMuxSel,
  output logic       accWrEn,
  output logic       stall,
  output logic       uartRdReq,
  input  logic       uartRdAck,
  output logic       spiRdReq,
  input  logic       spiRdAck,
  output logic       rdErr
);

  localparam logic [2:0]       SRC_UART_DATA = 3'd4;
  localparam logic [2:0]       SRC_SPI_BUF   = 3'd7;
  localparam logic [CNT_W-1:0] TERM_CNT      = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    WRITE    = 2'd2
  } state_t;

  state_t           state_r;
  state_t           nextState_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] nextCnt_s;
  logic [2:0]       src_r;
  logic [2:0]       nextSrc_s;
  logic             accept_s;
  logic             isHandshake_s;
  logic             ack_s;
  logic             timeout_s;
  logic             load_s;
  logic [2:0]       loadSel_s;

  assign reqReady = (state_r == IDLE);

  // Request acceptance, source classification and the ack that belongs to the pending source
  always_comb begin
    accept_s      = reqValid && (state_r == IDLE);
    isHandshake_s = 1'b0;
    ack_s         = 1'b0;
    nextSrc_s     = src_r;
    if ((reqSrc == SRC_UART_DATA) || (reqSrc == SRC_SPI_BUF)) begin
      isHandshake_s = 1'b1;
    end else begin
      isHandshake_s = 1'b0;
    end
    if (src_r == SRC_SPI_BUF) begin
      ack_s = spiRdAck;
    end else begin
      ack_s = uartRdAck;
    end
    if (accept_s) begin
      nextSrc_s = reqSrc;
    end else begin
      nextSrc_s = src_r;
    end
  end

  // Next-state, counter and load decisions; an ack on the terminal count still wins
  always_comb begin
    nextState_s = state_r;
    nextCnt_s   = cnt_r;
    timeout_s   = 1'b0;
    load_s      = 1'b0;
    loadSel_s   = accMuxSel;
    case (state_r)
      IDLE: begin
        if (accept_s && isHandshake_s) begin
          nextState_s = WAIT_ACK;
          nextCnt_s   = {CNT_W{1'b0}};
        end else if (accept_s) begin
          load_s    = 1'b1;
          loadSel_s = reqSrc;
        end else begin
          nextState_s = IDLE;
        end
      end
      WAIT_ACK: begin
        if (ack_s) begin
          nextState_s = WRITE;
          load_s      = 1'b1;
          loadSel_s   = src_r;
        end else if (cnt_r == TERM_CNT) begin
          nextState_s = IDLE;
          timeout_s   = 1'b1;
        end else begin
          nextCnt_s = cnt_r + CNT_W'(1);
        end
      end
      WRITE: begin
        nextState_s = IDLE;
      end
      default: begin
        nextState_s = IDLE;
      end
    endcase
  end

  // State and registered outputs, all derived from the next state so they align with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      src_r     <= 3'd0;
      accMuxSel <= 3'd0;
      accWrEn   <= 1'b0;
      stall     <= 1'b0;
      uartRdReq <= 1'b0;
      spiRdReq  <= 1'b0;
      rdErr     <= 1'b0;
    end else begin
      state_r   <= nextState_s;
      cnt_r     <= nextCnt_s;
      src_r     <= nextSrc_s;
      accMuxSel <= loadSel_s;
      accWrEn   <= load_s;
      stall     <= (nextState_s != IDLE);
      uartRdReq <= (nextState_s == WAIT_ACK) && (nextSrc_s == SRC_UART_DATA);
      spiRdReq  <= (nextState_s == WAIT_ACK) && (nextSrc_s == SRC_SPI_BUF);
      rdErr     <= timeout_s;
    end
  end

endmodule

// File: tb/tb_acc_load_sequencer.sv
// Self-checking bench for acc_load_sequencer: directed scenarios plus randomized
// transactions checked against a transaction-level expectation model.
module tb_acc_load_sequencer;

  localparam int TO   = 15;
  localparam int WIN  = TO + 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       reqValid;
  logic [2:0] reqSrc;
  logic       reqReady;
  logic [2:0] accMuxSel;
  logic       accWrEn;
  logic       stall;
  logic       uartRdReq;
  logic       uartRdAck;
  logic       spiRdReq;
  logic       spiRdAck;
  logic       rdErr;

  int nTests = 0;
  int nFail  = 0;

  acc_load_sequencer #(.TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .reqValid(reqValid), .reqSrc(reqSrc), .reqReady(reqReady),
    .accMuxSel(accMuxSel), .accWrEn(accWrEn), .stall(stall),
    .uartRdReq(uartRdReq), .uartRdAck(uartRdAck), .spiRdReq(spiRdReq), .spiRdAck(spiRdAck),
    .rdErr(rdErr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one handshake request and observes the following WIN cycles (no judgement here).
  // Cycle 1 is the first cycle after acceptance; ackAt/strayAt name the cycle an ack is driven.
  task automatic do_hs(input logic [2:0] src, input int ackAt, input int strayAt,
                       output int reqCyc, output int otherCyc, output int stallCyc,
                       output int wrCnt, output int wrCyc, output logic [2:0] wrMux,
                       output int errCnt, output int errCyc, output int readyCnt,
                       output logic [2:0] endMux);
    logic mine;
    logic other;
    reqCyc = 0; otherCyc = 0; stallCyc = 0; wrCnt = 0; wrCyc = 0; wrMux = 3'd0;
    errCnt = 0; errCyc = 0; readyCnt = 0;
    reqValid = 1'b1;
    reqSrc   = src;
    tick();
    reqValid = 1'b0;
    reqSrc   = 3'($urandom_range(7, 0));
    for (int c = 1; c <= WIN; c++) begin
      mine  = (src == 3'd4) ? uartRdReq : spiRdReq;
      other = (src == 3'd4) ? spiRdReq : uartRdReq;
      if (mine) reqCyc++;
      if (other) otherCyc++;
      if (stall) stallCyc++;
      if (reqReady) readyCnt++;
      if (accWrEn) begin wrCnt++; wrCyc = c; wrMux = accMuxSel; end
      if (rdErr) begin errCnt++; errCyc = c; end
      uartRdAck = ((src == 3'd4) && (c == ackAt)) || ((src == 3'd7) && (c == strayAt));
      spiRdAck  = ((src == 3'd7) && (c == ackAt)) || ((src == 3'd4) && (c == strayAt));
      tick();
    end
    uartRdAck = 1'b0;
    spiRdAck  = 1'b0;
    endMux    = accMuxSel;
  endtask

  task automatic test_reset();
    reset = 1'b1; reqValid = 1'b0; reqSrc = 3'd0; uartRdAck = 1'b0; spiRdAck = 1'b0;
    repeat (2) tick();
    nTests++; if (reqReady !== 1'b1) begin nFail++; $display("FAIL reset_ready: got %b want 1", reqReady); end
    nTests++; if (accMuxSel !== 3'd0) begin nFail++; $display("FAIL reset_mux: got %0d want 0", accMuxSel); end
    nTests++;
    if ({accWrEn, stall, uartRdReq, spiRdReq, rdErr} !== 5'b00000) begin
      nFail++; $display("FAIL reset_outs: got %b want 00000", {accWrEn, stall, uartRdReq, spiRdReq, rdErr});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [2:0] srcs [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6};
    for (int i = 0; i < 6; i++) begin
      reqValid = 1'b1;
      reqSrc   = srcs[i];
      nTests++; if (reqReady !== 1'b1) begin nFail++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, reqReady); end
      tick();
      nTests++;
      if (accWrEn !== 1'b1 || accMuxSel !== srcs[i] || stall !== 1'b0) begin
        nFail++; $display("FAIL b2b_load[%0d]: got wr=%b sel=%0d stall=%b want wr=1 sel=%0d stall=0",
                          i, accWrEn, accMuxSel, stall, srcs[i]);
      end
    end
    reqValid = 1'b0;
    reqSrc   = 3'd2;
    tick();
    nTests++;
    if (accWrEn !== 1'b0 || accMuxSel !== 3'd6 || uartRdReq !== 1'b0 || spiRdReq !== 1'b0) begin
      nFail++; $display("FAIL b2b_hold: got wr=%b sel=%0d ureq=%b sreq=%b want wr=0 sel=6 reqs=0",
                        accWrEn, accMuxSel, uartRdReq, spiRdReq);
    end
  endtask

  task automatic test_uart_ack();
    int rq, ot, st, wc, wy, ec, ey, rc;
    logic [2:0] wm, em;
    do_hs(3'd4, 3, 0, rq, ot, st, wc, wy, wm, ec, ey, rc, em);
    nTests++; if (rq !== 3) begin nFail++; $display("FAIL uart_req_cycles: got %0d want 3", rq); end
    nTests++; if (st !== 4) begin nFail++; $display("FAIL uart_stall_cycles: got %0d want 4", st); end
    nTests++;
    if (wc !== 1 || wy !== 4 || wm !== 3'd4) begin
      nFail++; $display("FAIL uart_write: got n=%0d cyc=%0d sel=%0d want n=1 cyc=4 sel=4", wc, wy, wm);
    end
    nTests++; if (rc !== WIN - 4) begin nFail++; $display("FAIL uart_ready: got %0d want %0d", rc, WIN - 4); end
    nTests++; if (ec !== 0 || ot !== 0) begin nFail++; $display("FAIL uart_err_other: got err=%0d other=%0d want 0 0", ec, ot); end
  endtask

  task automatic test_spi_timeout();
    int rq, ot, st, wc, wy, ec, ey, rc;
    logic [2:0] wm, em;
    do_hs(3'd7, 0, 0, rq, ot, st, wc, wy, wm, ec, ey, rc, em);
    nTests++; if (rq !== TO + 1) begin nFail++; $display("FAIL tmo_req_cycles: got %0d want %0d", rq, TO + 1); end
    nTests++;
    if (ec !== 1 || ey !== TO + 2) begin
      nFail++; $display("FAIL tmo_err: got n=%0d cyc=%0d want n=1 cyc=%0d", ec, ey, TO + 2);
    end
    nTests++; if (wc !== 0) begin nFail++; $display("FAIL tmo_no_write: got %0d want 0", wc); end
    nTests++; if (st !== TO + 1) begin nFail++; $display("FAIL tmo_stall: got %0d want %0d", st, TO + 1); end
    nTests++; if (em !== 3'd4) begin nFail++; $display("FAIL tmo_mux_hold: got %0d want 4", em); end
  endtask

  task automatic test_ack_at_terminal();
    int rq, ot, st, wc, wy, ec, ey, rc;
    logic [2:0] wm, em;
    do_hs(3'd7, TO + 1, 0, rq, ot, st, wc, wy, wm, ec, ey, rc, em);
    nTests++;
    if (wc !== 1 || wm !== 3'd7 || wy !== TO + 2) begin
      nFail++; $display("FAIL term_write: got n=%0d sel=%0d cyc=%0d want n=1 sel=7 cyc=%0d", wc, wm, wy, TO + 2);
    end
    nTests++; if (ec !== 0) begin nFail++; $display("FAIL term_no_err: got %0d want 0", ec); end
    nTests++; if (st !== TO + 2) begin nFail++; $display("FAIL term_stall: got %0d want %0d", st, TO + 2); end
  endtask

  task automatic test_stray_ack();
    int rq, ot, st, wc, wy, ec, ey, rc;
    logic [2:0] wm, em;
    do_hs(3'd4, 6, 2, rq, ot, st, wc, wy, wm, ec, ey, rc, em);
    nTests++;
    if (wc !== 1 || wy !== 7 || wm !== 3'd4) begin
      nFail++; $display("FAIL stray_write: got n=%0d cyc=%0d sel=%0d want n=1 cyc=7 sel=4", wc, wy, wm);
    end
    nTests++; if (rq !== 6 || ot !== 0) begin nFail++; $display("FAIL stray_reqs: got mine=%0d other=%0d want 6 0", rq, ot); end
  endtask

  task automatic test_reset_mid();
    reqValid = 1'b1;
    reqSrc   = 3'd4;
    tick();
    reqValid = 1'b0;
    tick();
    nTests++; if (uartRdReq !== 1'b1) begin nFail++; $display("FAIL rstmid_pre: got ureq=%b want 1", uartRdReq); end
    #2 reset = 1'b1;
    #1;
    nTests++;
    if ({uartRdReq, stall, accWrEn, reqReady} !== 4'b0001) begin
      nFail++; $display("FAIL rstmid_async: got ureq/stall/wr/ready=%b want 0001", {uartRdReq, stall, accWrEn, reqReady});
    end
    tick();
    reset    = 1'b0;
    reqValid = 1'b1;
    reqSrc   = 3'd1;
    nTests++; if (reqReady !== 1'b1) begin nFail++; $display("FAIL rstmid_ready: got %b want 1", reqReady); end
    tick();
    reqValid = 1'b0;
    nTests++;
    if (accWrEn !== 1'b1 || accMuxSel !== 3'd1 || stall !== 1'b0) begin
      nFail++; $display("FAIL rstmid_load: got wr=%b sel=%0d stall=%b want 1 1 0", accWrEn, accMuxSel, stall);
    end
    tick();
  endtask

  task automatic test_random();
    int rq, ot, st, wc, wy, ec, ey, rc;
    logic [2:0] wm, em;
    logic [2:0] lastMux;
    logic [2:0] src;
    int ackAt, strayAt, expReq, expStall;
    bit hit;
    lastMux = 3'd1;
    for (int t = 0; t < 40; t++) begin
      src = 3'($urandom_range(7, 0));
      if (src == 3'd4 || src == 3'd7) begin
        ackAt   = $urandom_range(TO + 3, 0);
        strayAt = $urandom_range(TO + 2, 0);
        hit      = (ackAt >= 1) && (ackAt <= TO + 1);
        expReq   = hit ? ackAt : TO + 1;
        expStall = hit ? ackAt + 1 : TO + 1;
        if (hit) lastMux = src;
        do_hs(src, ackAt, strayAt, rq, ot, st, wc, wy, wm, ec, ey, rc, em);
        nTests++;
        if (rq !== expReq || ot !== 0 || st !== expStall || rc !== WIN - expStall) begin
          nFail++; $display("FAIL rnd_hs_timing[%0d]: got req=%0d other=%0d stall=%0d ready=%0d want %0d 0 %0d %0d",
                            t, rq, ot, st, rc, expReq, expStall, WIN - expStall);
        end
        nTests++;
        if (wc !== (hit ? 1 : 0) || ec !== (hit ? 0 : 1) || em !== lastMux) begin
          nFail++; $display("FAIL rnd_hs_result[%0d]: got wr=%0d err=%0d sel=%0d want %0d %0d %0d",
                            t, wc, ec, em, hit ? 1 : 0, hit ? 0 : 1, lastMux);
        end
      end else begin
        reqValid = 1'b1;
        reqSrc   = src;
        tick();
        reqValid = 1'b0;
        lastMux  = src;
        nTests++;
        if (accWrEn !== 1'b1 || accMuxSel !== lastMux || stall !== 1'b0 || rdErr !== 1'b0) begin
          nFail++; $display("FAIL rnd_direct[%0d]: got wr=%b sel=%0d stall=%b err=%b want 1 %0d 0 0",
                            t, accWrEn, accMuxSel, stall, rdErr, lastMux);
        end
        if ($urandom_range(1, 0) == 1) begin
          tick();
          nTests++;
          if (accWrEn !== 1'b0 || accMuxSel !== lastMux) begin
            nFail++; $display("FAIL rnd_idle[%0d]: got wr=%b sel=%0d want 0 %0d", t, accWrEn, accMuxSel, lastMux);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_uart_ack();
    test_spi_timeout();
    test_ack_at_terminal();
    test_stray_ack();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
